// File: rtl/sr_pack_controller_pkg.sv
// Shared constants and state encoding for the byte-packing sequencing controller.
package sr_pack_controller_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;

  localparam logic [1:0] StateClear = 2'd0;
  localparam logic [1:0] StateFill  = 2'd1;
  localparam logic [1:0] StatePad   = 2'd2;
  localparam logic [1:0] StateEmit  = 2'd3;

  typedef enum logic [1:0] {
    StClear = StateClear,
    StFill  = StateFill,
    StPad   = StatePad,
    StEmit  = StateEmit
  } state_e;

endpackage

// File: rtl/sr_pack_controller.sv
// Sequences the 8-to-32 packing shift register: fills from a byte stream, zero-pads short
// packets and presents each completed word with a valid/ready handshake.
module sr_pack_controller
  import sr_pack_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              sr_en,
  output logic              sr_rst,
  output logic              sr_last,
  output logic [BYTE_W-1:0] sr_data,
  input  logic              sr_full,
  input  logic [WORD_W-1:0] sr_word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_last,
  output logic [2:0]        word_bytes
);

  localparam logic [2:0] LastIdx   = 3'(BYTES_PER_WORD - 1);
  localparam logic [2:0] FullBytes = 3'(BYTES_PER_WORD);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic [2:0] bytes_q, bytes_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= 3'd0;
      last_q  <= 1'b0;
      bytes_q <= FullBytes;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      bytes_q <= bytes_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    bytes_d    = bytes_q;
    byte_ready = 1'b0;
    sr_en      = 1'b0;
    sr_rst     = 1'b0;
    sr_last    = 1'b0;
    sr_data    = byte_in;
    word_valid = 1'b0;
    word_data  = sr_word;
    word_last  = 1'b0;
    word_bytes = 3'd0;

    if (rst) begin
      sr_rst = 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          sr_rst  = 1'b1;
          cnt_d   = 3'd0;
          bytes_d = FullBytes;
          state_d = StFill;
        end
        StFill: begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            sr_en = 1'b1;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LastIdx) begin
              // A last flag on the final byte needs no padding.
              last_d  = byte_last;
              state_d = StEmit;
            end else if (byte_last) begin
              last_d  = 1'b1;
              bytes_d = cnt_q + 3'd1;
              state_d = StPad;
            end
          end
        end
        StPad: begin
          sr_en   = 1'b1;
          sr_last = 1'b1;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == LastIdx) state_d = StEmit;
        end
        StEmit: begin
          word_valid = sr_full;
          word_last  = last_q;
          word_bytes = bytes_q;
          if (sr_full && word_ready) begin
            cnt_d   = 3'd0;
            last_d  = 1'b0;
            state_d = StClear;
          end
        end
        default: state_d = StClear;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_pack_controller.sv
// Self-checking bench: models the shift register beside the controller and checks emitted
// words against a packet-level reference built from the accepted byte stream.
module tb_sr_pack_controller;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [2:0]  nb;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_last;
  logic        byte_ready;
  logic        sr_en, sr_rst, sr_last;
  logic [7:0]  sr_data;
  logic        sr_full;
  logic [31:0] sr_word;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_last;
  logic [2:0]  word_bytes;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt = 0, acc_cnt = 0, pad_cnt = 0, bad_en = 0;
  bit rand_ready = 1'b0;

  word_t got_q[$];
  word_t exp_q[$];
  logic [31:0] acc_word = 32'h0;
  int          acc_n    = 0;

  logic [2:0]  sr_cnt;

  always #5 clk = ~clk;

  sr_pack_controller dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .sr_en      (sr_en),
    .sr_rst     (sr_rst),
    .sr_last    (sr_last),
    .sr_data    (sr_data),
    .sr_full    (sr_full),
    .sr_word    (sr_word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_bytes (word_bytes)
  );

  // Behavioural 8-to-32 shift register sitting beside the controller.
  always @(posedge clk) begin
    if (sr_rst) begin
      sr_cnt  <= 3'd0;
      sr_word <= 32'h0;
    end else if (sr_en) begin
      sr_word <= {sr_word[23:0], (sr_last ? 8'h00 : sr_data)};
      sr_cnt  <= sr_cnt + 3'd1;
    end
  end
  assign sr_full = (sr_cnt == 3'd4);

  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) got_q.push_back({word_data, word_last, word_bytes});
    if (sr_en) en_cnt++;
    if (byte_valid && byte_ready) acc_cnt++;
    if (sr_en && sr_last) pad_cnt++;
    if (byte_ready && (sr_en !== byte_valid)) bad_en++;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) word_ready = 1'($urandom_range(0, 1));
  end

  // Reference: bytes are packed MSB-first; a word closes at 4 bytes or on a last byte.
  task automatic model_byte(input logic [7:0] b, input logic last);
    acc_word = acc_word | ({24'h0, b} << (24 - 8 * acc_n));
    acc_n++;
    if (acc_n == 4 || last) begin
      exp_q.push_back({acc_word, last, 3'(acc_n)});
      acc_word = 32'h0;
      acc_n    = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int max_gap);
    int n = 0;
    repeat ($urandom_range(0, max_gap)) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    byte_last  = last;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL send_byte timeout: byte_ready=%0b required=1", byte_ready);
        n_checks++;
        break;
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    model_byte(b, last);
  endtask

  task automatic wait_words(input int n);
    int c = 0;
    while (got_q.size() < n && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; word_ready = 1'b1; byte_valid = 1'b0; byte_in = 8'h0; byte_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({sr_rst, sr_en, sr_last, byte_ready, word_valid, word_last, word_bytes} !== 9'b100000000)
      $display("FAIL reset_outputs: got %b required 100000000",
               {sr_rst, sr_en, sr_last, byte_ready, word_valid, word_last, word_bytes});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sr_rst, byte_ready} !== 2'b10)
      $display("FAIL reset_clear_cycle: sr_rst,byte_ready=%b required 10", {sr_rst, byte_ready});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({sr_rst, byte_ready} !== 2'b01)
      $display("FAIL reset_first_ready: sr_rst,byte_ready=%b required 01", {sr_rst, byte_ready});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_full_words();
    logic [7:0] seq [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    word_t g, e;
    for (int i = 0; i < 8; i++) begin
      send_byte(seq[i], 1'b0, 0);
      if (i % 4 == 3) begin
        n_checks++;
        if (word_valid !== 1'b1)
          $display("FAIL full_valid_latency word %0d: word_valid=%0b required 1", i / 4, word_valid);
        else n_pass++;
      end
    end
    wait_words(2);
    n_checks++;
    if (got_q.size() != 2) $display("FAIL full_count: got %0d words required 2", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL full_word: got %h required %h", g, e);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_padding();
    word_t g, e;
    int p0 = pad_cnt;
    send_byte(8'hA1, 1'b0, 0);
    send_byte(8'hB2, 1'b1, 0);
    wait_words(1);
    n_checks++;
    if (pad_cnt - p0 != 2) $display("FAIL pad_cycles: got %0d required 2", pad_cnt - p0);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 1) $display("FAIL pad_count: got %0d words required 1", got_q.size());
    else n_pass++;
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e || e !== {32'hA1B20000, 1'b1, 3'd2})
        $display("FAIL pad_word: got %h required %h", g, {32'hA1B20000, 1'b1, 3'd2});
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_last_on_fourth();
    word_t g, e;
    int p0 = pad_cnt;
    send_byte(8'h01, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    send_byte(8'h03, 1'b0, 0);
    send_byte(8'h04, 1'b1, 0);
    n_checks++;
    if (word_valid !== 1'b1) $display("FAIL last4_latency: word_valid=%0b required 1", word_valid);
    else n_pass++;
    wait_words(1);
    n_checks++;
    if (pad_cnt != p0) $display("FAIL last4_pad: got %0d pad cycles required 0", pad_cnt - p0);
    else n_pass++;
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL last4_word: got %h required %h", g, e);
      else n_pass++;
    end else begin
      n_checks++;
      $display("FAIL last4_word: got %0d words required 1", got_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    word_t g, e;
    logic [31:0] held;
    int e0;
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 0);
    held = word_data;
    e0 = en_cnt;
    byte_valid = 1'b1; byte_in = 8'h5A;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if ({word_valid, byte_ready} !== 2'b10 || word_data !== held || word_bytes !== 3'd4)
        $display("FAIL bp_hold: valid,ready=%b data=%h bytes=%0d required 10 %h 4",
                 {word_valid, byte_ready}, word_data, word_bytes, held);
      else n_pass++;
    end
    n_checks++;
    if (en_cnt != e0) $display("FAIL bp_sr_en: got %0d enables required 0", en_cnt - e0);
    else n_pass++;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    word_ready = 1'b1;
    wait_words(1);
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL bp_word: got %h required %h", g, e);
      else n_pass++;
    end else begin
      n_checks++;
      $display("FAIL bp_word: got %0d words required 1", got_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_word();
    word_t g, e;
    send_byte(8'hC1, 1'b0, 0);
    send_byte(8'hC2, 1'b0, 0);
    send_byte(8'hC3, 1'b0, 0);
    acc_word = 32'h0; acc_n = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sr_rst, byte_ready} !== 2'b10)
      $display("FAIL rstmid_clear: sr_rst,byte_ready=%b required 10", {sr_rst, byte_ready});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (byte_ready !== 1'b1) $display("FAIL rstmid_fill: byte_ready=%0b required 1", byte_ready);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 0) $display("FAIL rstmid_discard: got %0d words required 0", got_q.size());
    else n_pass++;
    @(posedge clk); #1;
    send_byte(8'hDE, 1'b0, 0);
    send_byte(8'hAD, 1'b0, 0);
    send_byte(8'hBE, 1'b0, 0);
    send_byte(8'hEF, 1'b0, 0);
    wait_words(1);
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e || e.data !== 32'hDEADBEEF)
        $display("FAIL rstmid_word: got %h required %h", g, {32'hDEADBEEF, 1'b0, 3'd4});
      else n_pass++;
    end else begin
      n_checks++;
      $display("FAIL rstmid_word: got %0d words required 1", got_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stalled_source();
    word_t g, e;
    int e0 = en_cnt, a0 = acc_cnt, b0 = bad_en;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0, 3);
    wait_words(2);
    n_checks++;
    if (en_cnt - e0 != 8 || acc_cnt - a0 != 8)
      $display("FAIL stall_enables: sr_en=%0d accepted=%0d required 8 8", en_cnt - e0, acc_cnt - a0);
    else n_pass++;
    n_checks++;
    if (bad_en != b0) $display("FAIL stall_en_match: got %0d stray cycles required 0", bad_en - b0);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 2) $display("FAIL stall_count: got %0d words required 2", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL stall_word: got %h required %h", g, e);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random_packets();
    word_t g, e;
    int n_exp;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send_byte(8'($urandom), (i == 39) || ($urandom_range(0, 4) == 0), 2);
    n_exp = exp_q.size();
    wait_words(n_exp);
    rand_ready = 1'b0;
    @(posedge clk); #1;
    word_ready = 1'b1;
    n_checks++;
    if (got_q.size() != n_exp)
      $display("FAIL rand_count: got %0d words required %0d", got_q.size(), n_exp);
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL rand_word: got %h required %h", g, e);
      else n_pass++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_padding();
    test_last_on_fourth();
    test_backpressure();
    test_reset_mid_word();
    test_stalled_source();
    test_random_packets();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_pack_controller.md
# sr_pack_controller

Sequencing controller for the 8-to-32-bit byte-packing shift register. Accepts a byte stream with valid/ready handshake and an end-of-packet flag, drives the register's enable, clear and zero-pad controls, and presents each completed 32-bit word downstream with its own valid/ready handshake. Sits between the byte source and the word consumer; the shift register is instantiated beside it in the parent.

## Interface
- Parameters: none. Word width is fixed at 4 bytes by the shift register.
- Clock/reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `byte_valid` in 1: source byte present.
- `byte_in` in 8: source byte.
- `byte_last` in 1: qualifies `byte_in` as the final byte of a packet.
- `byte_ready` out 1: controller accepts a byte this cycle.
- `sr_en` out 1: shift-register enable.
- `sr_rst` out 1: shift-register counter clear.
- `sr_last` out 1: shift-register zero-pad select.
- `sr_data` out 8: byte to the shift register; equals `byte_in`.
- `sr_full` in 1: shift register holds 4 bytes.
- `sr_word` in 32: shift register word output.
- `word_valid` out 1: `word_data` is valid.
- `word_ready` in 1: consumer takes the word.
- `word_data` out 32: packed word; first byte accepted sits in [31:24].
- `word_last` out 1: word ends a packet.
- `word_bytes` out 3: real (non-pad) bytes in the word, 1..4.

## Operation
- States: CLEAR, FILL, PAD, EMIT.
- CLEAR: `sr_rst`=1. Go to FILL next cycle.
- FILL: `byte_ready`=1. On `byte_valid`, drive `sr_en`=1 and increment the internal `cnt` (0..4).
  - If the accepted byte brings `cnt` to 4, go to EMIT.
  - Else if `byte_last`=1, set `last_f`, record `word_bytes`=`cnt`+1 and go to PAD.
- PAD: `byte_ready`=0. Drive `sr_en`=1 and `sr_last`=1 every cycle, incrementing `cnt`. When `cnt` reaches 4, go to EMIT.
- EMIT: `sr_en`=0, so the word is stable.
  - `word_valid` = `sr_full`.
  - `word_data` = `sr_word`.
  - `word_last` = `last_f`.
  - On `word_valid` and `word_ready`: clear `last_f` and `cnt`, go to CLEAR.
- `word_bytes` is 4 unless set in FILL on a short last byte.
- `byte_last` on the 4th byte: go straight to EMIT with `word_last`=1 and `word_bytes`=4, no padding.
- Outputs that are not asserted are 0. `sr_data` always passes `byte_in` through.

## Timing
- Reset: state goes to CLEAR; `cnt`=0, `last_f`=0.
  - During `rst`, `sr_rst`=1 and all other outputs are 0 (`word_data` = `sr_word` pass-through).
  - `rst` mid-operation discards any partial or pending word.
- First `byte_ready` comes 2 cycles after `rst` deasserts (1 cycle in CLEAR).
- If the 4th byte is accepted at edge t, `word_valid` is high in the cycle after t.
- Padding takes 4−k cycles after a last byte at position k.
- Minimum word period is 6 cycles: 4 FILL + 1 EMIT + 1 CLEAR.
- While `word_ready`=0, `word_valid`/`word_data`/`word_last`/`word_bytes` hold unchanged.
- Word handshake rules:
  - `word_valid` never deasserts without a transfer.
  - `word_valid` does not depend combinationally on `word_ready`.
- `byte_ready` is 0 in CLEAR, PAD and EMIT. A `byte_valid` in those states is ignored and the source must hold its byte.
- `sr_full` low in EMIT (integration fault) keeps `word_valid` low; the FSM waits.

## Structure
- Shared package holds:
  - state encoding localparams (2-bit: CLEAR, FILL, PAD, EMIT);
  - `BYTES_PER_WORD`=4;
  - `BYTE_W`=8, `WORD_W`=32.
- Single flat module: one state register, 3-bit `cnt`, `last_f`, 3-bit `word_bytes` register, and combinational output decode. No sub-module.
- The parent instantiates `sr_pack_controller` and the existing shift register side by side.

## Test plan
- Full words: 8 bytes 0x11..0x88 back-to-back, `word_ready`=1 → words 0x11223344 then 0x55667788, each with `word_bytes`=4, `word_last`=0 and `word_valid` 1 cycle after the 4th byte.
- Padding: bytes 0xA1, 0xB2 with `byte_last` on 0xB2 → 2 PAD cycles with `sr_last`=1, then word 0xA1B20000 with `word_last`=1 and `word_bytes`=2.
- Last on 4th byte: 0x01,0x02,0x03,0x04 with `byte_last` on 0x04 → 0x01020304, `word_last`=1, `word_bytes`=4, no PAD cycles.
- Backpressure: hold `word_ready`=0 for 5 cycles in EMIT → `word_valid` and data stable, `byte_ready`=0; the next word is intact after release.
- Reset mid-word: 3 bytes accepted, then `rst` for 1 cycle → no word emitted, CLEAR then FILL. The next 4 bytes 0xDE,0xAD,0xBE,0xEF yield 0xDEADBEEF.
- Stalled source: `byte_valid` toggled randomly with an 8-byte stream → same words as the back-to-back case, and `sr_en` only pulses on accepted bytes.
